// File: rtl/mini_alu_stack_core_pkg.sv
// Shared definitions for the mini ALU stack core:
// default widths, opcode encoding and instruction field sizes.
package mini_alu_stack_core_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_RAM_ADDR_WIDTH = 8;
    localparam int DEF_IP_WIDTH       = 16;
    localparam int DEF_STACK_DEPTH    = 8;
    localparam int DEF_LED_WIDTH      = 8;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'd0,
        OP_LED   = 4'd1,
        OP_BLE   = 4'd2,
        OP_STO   = 4'd3,
        OP_ADD   = 4'd4,
        OP_JMP   = 4'd5,
        OP_SUB   = 4'd6,
        OP_MUL   = 4'd7,
        OP_CALL  = 4'd8,
        OP_RET   = 4'd9,
        OP_BNLCD = 4'd10,
        OP_LCD   = 4'd11,
        OP_SHL   = 4'd12,
        OP_SHR   = 4'd13,
        OP_HALT  = 4'd14,
        OP_RSV   = 4'd15
    } opcode_e;

endpackage

// File: rtl/mini_alu_stack_core_return_stack.sv
// Hardware return-address stack for CALL/RET.
// Reset clears only the pointer; entries keep their contents.
module return_stack
    import mini_alu_stack_core_pkg::*;
#(
    parameter int WIDTH = DEF_IP_WIDTH,
    parameter int DEPTH = DEF_STACK_DEPTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iPush,
    input  logic             iPop,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oTop,
    output logic             oFull,
    output logic             oEmpty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    sp_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    top_idx;

    assign top_idx = AW'(sp_q - PW'(1));
    assign oTop    = mem_q[top_idx];
    assign oFull   = (sp_q == PW'(DEPTH));
    assign oEmpty  = (sp_q == '0);

    // Stack pointer: push has priority, both guarded against misuse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sp_q <= '0;
        end else if (iPush && !oFull) begin
            sp_q <= sp_q + PW'(1);
        end else if (iPop && !oEmpty) begin
            sp_q <= sp_q - PW'(1);
        end
    end

    // Entry storage, written at the slot the pointer currently names
    always_ff @(posedge Clock) begin
        if (iPush && !oFull) begin
            mem_q[sp_q[AW-1:0]] <= iData;
        end
    end

endmodule

// File: rtl/mini_alu_stack_core.sv
// Single-issue MiniAlu core: ROM fetch, register RAM, return stack,
// LCD handshake stall and HALT / stack-error stop state.
module mini_alu_stack_core
    import mini_alu_stack_core_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
    parameter int IP_WIDTH       = DEF_IP_WIDTH,
    parameter int STACK_DEPTH    = DEF_STACK_DEPTH,
    parameter int LED_WIDTH      = DEF_LED_WIDTH
) (
    input  logic                              Clock,
    input  logic                              Reset,
    output logic [IP_WIDTH-1:0]               oIP,
    input  logic [OPC_W+3*RAM_ADDR_WIDTH-1:0] iInstruction,
    output logic [LED_WIDTH-1:0]              oLed,
    output logic [7:0]                        oLcdData,
    output logic                              oLcdValid,
    input  logic                              iLcdReady,
    output logic                              oHalted,
    output logic                              oStackError
);
    localparam int AW = RAM_ADDR_WIDTH;
    localparam int IW = OPC_W + 3 * AW;
    localparam int RD = 2 ** AW;

    logic [IW-1:0]         ir_q, ir_d;
    logic [IP_WIDTH-1:0]   pc_q, pc_d, ip, tgt;
    logic [LED_WIDTH-1:0]  led_q, led_d;
    logic                  halted_q, halted_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] ram_q [RD];

    opcode_e               op;
    logic [AW-1:0]         dst, s1, s0;
    logic [DATA_WIDTH-1:0] r1, r0, imm, wdata;
    logic                  we, taken, freeze;
    logic                  push, pop, lcd_valid;
    logic [IP_WIDTH-1:0]   stk_top;
    logic                  stk_full, stk_empty;

    assign op  = opcode_e'(ir_q[IW-1 -: OPC_W]);
    assign dst = ir_q[3*AW-1 -: AW];
    assign s1  = ir_q[2*AW-1 -: AW];
    assign s0  = ir_q[AW-1:0];
    assign r1  = ram_q[s1];
    assign r0  = ram_q[s0];
    assign imm = DATA_WIDTH'({s1, s0});

    return_stack #(
        .WIDTH (IP_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clock  (Clock),
        .Reset  (Reset),
        .iPush  (push),
        .iPop   (pop),
        .iData  (pc_q),
        .oTop   (stk_top),
        .oFull  (stk_full),
        .oEmpty (stk_empty)
    );

    // Decode the instruction in IR; a stop state or stall freezes fetch
    always_comb begin
        tgt       = IP_WIDTH'(dst);
        taken     = 1'b0;
        freeze    = halted_q;
        we        = 1'b0;
        wdata     = '0;
        push      = 1'b0;
        pop       = 1'b0;
        lcd_valid = 1'b0;
        led_d     = led_q;
        halted_d  = halted_q;
        err_d     = err_q;
        if (!halted_q) begin
            unique case (op)
                OP_LED: led_d = LED_WIDTH'(r1);
                OP_BLE: taken = (r1 <= r0);
                OP_STO: begin
                    we    = 1'b1;
                    wdata = imm;
                end
                OP_ADD: begin
                    we    = 1'b1;
                    wdata = r1 + r0;
                end
                OP_JMP: taken = 1'b1;
                OP_SUB: begin
                    we    = 1'b1;
                    wdata = r1 - r0;
                end
                OP_MUL: begin
                    we    = 1'b1;
                    wdata = r1 * r0;
                end
                OP_CALL: begin
                    if (stk_full) begin
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                        freeze   = 1'b1;
                    end else begin
                        push  = 1'b1;
                        taken = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                        freeze   = 1'b1;
                    end else begin
                        pop   = 1'b1;
                        taken = 1'b1;
                        tgt   = stk_top;
                    end
                end
                OP_BNLCD: taken = !iLcdReady;
                OP_LCD: begin
                    if (iLcdReady) lcd_valid = 1'b1;
                    else           freeze    = 1'b1;
                end
                OP_SHL: begin
                    we    = 1'b1;
                    wdata = r1 << r0[3:0];
                end
                OP_SHR: begin
                    we    = 1'b1;
                    wdata = r1 >> r0[3:0];
                end
                OP_HALT: begin
                    halted_d = 1'b1;
                    freeze   = 1'b1;
                end
                default: ;
            endcase
        end
        ip   = taken ? tgt : pc_q;
        pc_d = freeze ? pc_q : ip + IP_WIDTH'(1);
        ir_d = freeze ? ir_q : iInstruction;
    end

    // Fetch/control registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            led_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            led_q    <= led_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Register RAM write port; contents survive reset
    always_ff @(posedge Clock) begin
        if (we && !Reset) begin
            ram_q[dst] <= wdata;
        end
    end

    assign oIP         = ip;
    assign oLed        = led_q;
    assign oLcdData    = 8'({s1, s0});
    assign oLcdValid   = lcd_valid;
    assign oHalted     = halted_q;
    assign oStackError = err_q;

endmodule

// File: tb/tb_mini_alu_stack_core.sv
// Testbench for mini_alu_stack_core: directed programs plus random
// programs compared every cycle against an instruction-level model.
module tb_mini_alu_stack_core;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] oIP;
    logic [27:0] iInstruction;
    logic [7:0]  oLed;
    logic [7:0]  oLcdData;
    logic        oLcdValid;
    logic        iLcdReady = 1'b1;
    logic        oHalted;
    logic        oStackError;

    logic [27:0] rom [256];

    int n_pass = 0;
    int n_total = 0;

    assign iInstruction = rom[oIP[7:0]];

    mini_alu_stack_core dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oIP          (oIP),
        .iInstruction (iInstruction),
        .oLed         (oLed),
        .oLcdData     (oLcdData),
        .oLcdValid    (oLcdValid),
        .iLcdReady    (iLcdReady),
        .oHalted      (oHalted),
        .oStackError  (oStackError)
    );

    always #10 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [27:0] ins(input int op, input int d,
                                        input int a, input int b);
        logic [3:0] o4;
        logic [7:0] d8, a8, b8;
        o4 = op[3:0];
        d8 = d[7:0];
        a8 = a[7:0];
        b8 = b[7:0];
        return {o4, d8, a8, b8};
    endfunction

    // Instruction-level model: architectural state plus a queue stack
    logic [27:0] m_ir;
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_halt, m_err;
    logic [7:0]  m_led;
    logic [15:0] m_R [256];
    bit          m_ok = 0;

    always @(negedge Clock) begin
        int          op, d, a, b;
        logic [15:0] x1, x0, nip, tgt;
        bit          tk, frz, run, vld;
        op  = int'(m_ir[27:24]);
        d   = int'(m_ir[23:16]);
        a   = int'(m_ir[15:8]);
        b   = int'(m_ir[7:0]);
        x1  = m_R[a];
        x0  = m_R[b];
        run = !m_halt;
        tgt = 16'(d);
        tk  = 0;
        if (run) begin
            if (op == 2) tk = (x1 <= x0);
            if (op == 5) tk = 1;
            if (op == 8) tk = (m_stk.size() < 8);
            if (op == 9 && m_stk.size() > 0) begin
                tk  = 1;
                tgt = m_stk[$];
            end
            if (op == 10) tk = !iLcdReady;
        end
        nip = tk ? tgt : m_pc;
        vld = run && op == 11 && iLcdReady;
        frz = !run || op == 14 || (op == 11 && !iLcdReady)
              || (op == 8 && m_stk.size() == 8)
              || (op == 9 && m_stk.size() == 0);
        if (m_ok) begin
            check("ip", 32'(oIP), 32'(nip));
            check("lcd_valid", 32'(oLcdValid), 32'(vld));
            if (vld) check("lcd_data", 32'(oLcdData), 32'(b));
            check("led", 32'(oLed), 32'(m_led));
            check("halted", 32'(oHalted), 32'(m_halt));
            check("stack_err", 32'(oStackError), 32'(m_err));
        end
        if (Reset) begin
            m_ok   = 1;
            m_ir   = '0;
            m_pc   = '0;
            m_halt = 0;
            m_err  = 0;
            m_led  = '0;
            m_stk.delete();
        end else begin
            if (run) begin
                case (op)
                    1:  m_led = x1[7:0];
                    3:  m_R[d] = {a[7:0], b[7:0]};
                    4:  m_R[d] = x1 + x0;
                    6:  m_R[d] = x1 - x0;
                    7:  m_R[d] = x1 * x0;
                    8: begin
                        if (m_stk.size() < 8) m_stk.push_back(m_pc);
                        else begin
                            m_err  = 1;
                            m_halt = 1;
                        end
                    end
                    9: begin
                        if (m_stk.size() > 0) void'(m_stk.pop_back());
                        else begin
                            m_err  = 1;
                            m_halt = 1;
                        end
                    end
                    12: m_R[d] = x1 << x0[3:0];
                    13: m_R[d] = x1 >> x0[3:0];
                    14: m_halt = 1;
                    default: ;
                endcase
            end
            if (!frz) begin
                m_ir = rom[nip[7:0]];
                m_pc = nip + 16'd1;
            end
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #2;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock);
        #1 Reset = 1'b0;
        #1;
    endtask

    task automatic wait_halt(input string name, input int budget);
        for (int i = 0; i < budget && !oHalted; i++) cyc();
        check(name, 32'(oHalted), 32'd1);
    endtask

    int e3 [11] = '{0, 10, 20, 30, 21, 11, 1, 2, 3, 4, 4};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Add chain and oIP sequence
        clear_rom();
        rom[0] = ins(3, 1, 0, 5);
        rom[1] = ins(3, 2, 0, 3);
        rom[2] = ins(4, 3, 1, 2);
        rom[3] = ins(1, 0, 3, 0);
        rom[4] = ins(14, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            check("t1_ip_seq", 32'(oIP), 32'(k));
            cyc();
        end
        check("t1_led", 32'(oLed), 32'd8);
        check("t1_not_halted", 32'(oHalted), 32'd0);
        cyc();
        check("t1_halted", 32'(oHalted), 32'd1);
        check("t1_ip_frozen", 32'(oIP), 32'd5);

        // Reset while halted
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("rh_ip", 32'(oIP), 32'd0);
        check("rh_halt", 32'(oHalted), 32'd0);
        check("rh_led", 32'(oLed), 32'd0);
        check("rh_err", 32'(oStackError), 32'd0);

        // BLE loop then SUB wrap
        clear_rom();
        rom[0] = ins(3, 1, 0, 0);
        rom[1] = ins(3, 2, 0, 4);
        rom[2] = ins(3, 5, 0, 1);
        rom[3] = ins(4, 1, 1, 5);
        rom[4] = ins(2, 3, 1, 2);
        rom[5] = ins(6, 4, 2, 1);
        rom[6] = ins(1, 0, 4, 0);
        rom[7] = ins(14, 0, 0, 0);
        do_reset();
        wait_halt("t2_halt_wait", 100);
        check("t2_led", 32'(oLed), 32'hFF);
        check("t2_model_r4", 32'(m_R[4]), 32'hFFFF);
        check("t2_model_r1", 32'(m_R[1]), 32'd5);

        // Nested calls, depth 3
        clear_rom();
        rom[0]  = ins(8, 10, 0, 0);
        rom[1]  = ins(3, 6, 0, 7);
        rom[2]  = ins(1, 0, 6, 0);
        rom[3]  = ins(14, 0, 0, 0);
        rom[10] = ins(8, 20, 0, 0);
        rom[11] = ins(9, 0, 0, 0);
        rom[20] = ins(8, 30, 0, 0);
        rom[21] = ins(9, 0, 0, 0);
        rom[30] = ins(9, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 11; k++) begin
            check("t3_ip_seq", 32'(oIP), 32'(e3[k]));
            cyc();
        end
        check("t3_err", 32'(oStackError), 32'd0);
        check("t3_led", 32'(oLed), 32'd7);
        check("t3_model_sp", 32'(m_stk.size()), 32'd0);

        // Overflow: nine nested calls into an 8-deep stack
        clear_rom();
        for (int i = 0; i < 9; i++) rom[i] = ins(8, i + 1, 0, 0);
        do_reset();
        wait_halt("t4_halt_wait", 50);
        check("t4_err", 32'(oStackError), 32'd1);
        check("t4_ip", 32'(oIP), 32'd9);
        cyc();
        check("t4_ip_frozen", 32'(oIP), 32'd9);

        // Lone RET after reset
        clear_rom();
        rom[0] = ins(9, 0, 0, 0);
        do_reset();
        cyc();
        cyc();
        check("t4r_err", 32'(oStackError), 32'd1);
        check("t4r_halt", 32'(oHalted), 32'd1);
        check("t4r_ip", 32'(oIP), 32'd1);

        // LCD stall then single strobe
        clear_rom();
        rom[0] = ins(11, 0, 0, 8'h41);
        rom[1] = ins(3, 7, 0, 8'h22);
        rom[2] = ins(1, 0, 7, 0);
        rom[3] = ins(14, 0, 0, 0);
        iLcdReady = 1'b0;
        do_reset();
        cyc();
        for (int k = 0; k < 10; k++) begin
            check("t5_stall_ip", 32'(oIP), 32'd1);
            check("t5_stall_valid", 32'(oLcdValid), 32'd0);
            cyc();
        end
        iLcdReady = 1'b1;
        #1;
        check("t5_valid", 32'(oLcdValid), 32'd1);
        check("t5_data", 32'(oLcdData), 32'h41);
        cyc();
        check("t5_valid_off", 32'(oLcdValid), 32'd0);
        check("t5_ip_next", 32'(oIP), 32'd2);
        wait_halt("t5_halt_wait", 20);
        check("t5_led", 32'(oLed), 32'h22);

        // Reset in the middle of a stall
        iLcdReady = 1'b0;
        do_reset();
        cyc();
        cyc();
        cyc();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("rs_ip", 32'(oIP), 32'd0);
        check("rs_valid", 32'(oLcdValid), 32'd0);
        check("rs_halt", 32'(oHalted), 32'd0);
        check("rs_err", 32'(oStackError), 32'd0);
        iLcdReady = 1'b1;

        // Random programs, random LCD readiness
        for (int r = 0; r < 12; r++) begin
            clear_rom();
            for (int i = 0; i < 8; i++)
                rom[i] = ins(3, i, $urandom_range(0, 255),
                             $urandom_range(0, 255));
            for (int i = 8; i < 64; i++) begin
                int op, b;
                op = $urandom_range(0, 15);
                if ((op == 14 || op == 9) && $urandom_range(0, 3) != 0)
                    op = 4;
                b = (op == 3 || op == 11) ? $urandom_range(0, 255)
                                          : $urandom_range(0, 7);
                rom[i] = ins(op, $urandom_range(0, 63),
                             $urandom_range(0, 7), b);
            end
            do_reset();
            for (int c = 0; c < 300; c++) begin
                iLcdReady = ($urandom_range(0, 3) != 0);
                Reset = (r % 3 == 1 && c == 150);
                cyc();
            end
            Reset = 1'b0;
            iLcdReady = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
